// File: rtl/id_ex_reg_if.sv
// id_ex_reg_if: bundle between the decode stage, the ID/EX pipeline register
// and the execute/hazard logic.
//
// Signal groups
//   id_*        decode-stage values for the instruction currently in ID
//   hold        whole-pipeline freeze (memory wait)
//   flush       taken branch/jump resolved in EX; squash the decode slot
//   ex_*        registered values presented to the execute stage
//   load_stall  combinational: PC and IF/ID must hold this cycle
//   bubble_cnt  saturating count of load-use bubbles inserted
//   flush_cnt   saturating count of flush bubbles inserted
//
// Flow semantics: there is no valid/ready pair. id_valid marks a real
// instruction in the decode slot and ex_valid marks a real instruction in EX.
// An instruction advances from ID to EX on every rising edge unless hold is
// high (nothing moves) or a bubble is inserted (flush, or load_stall, which
// back-pressures PC and IF/ID so the same decode instruction is offered again).
//
// Modports
//   master  the decode/control side that drives id_*, hold and flush
//   slave   the ID/EX register itself
interface id_ex_reg_if;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_rs1_data;
    logic [31:0] id_rs2_data;
    logic [31:0] id_imm;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;
    logic        id_rs1_used;
    logic        id_rs2_used;
    logic        id_regwrite;
    logic        id_memread;
    logic        id_memwrite;
    logic [3:0]  id_alu_fun;
    logic        hold;
    logic        flush;

    logic        ex_valid;
    logic        ex_regwrite;
    logic        ex_memread;
    logic        ex_memwrite;
    logic        ex_rs1_used;
    logic        ex_rs2_used;
    logic [31:0] ex_pc;
    logic [31:0] ex_rs1_data;
    logic [31:0] ex_rs2_data;
    logic [31:0] ex_imm;
    logic [31:0] ex_rs1;
    logic [31:0] ex_rs2;
    logic [31:0] ex_rd;
    logic [3:0]  ex_alu_fun;
    logic        load_stall;
    logic [15:0] bubble_cnt;
    logic [15:0] flush_cnt;

    modport master (
        output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1, id_rs2, id_rd, id_rs1_used, id_rs2_used,
               id_regwrite, id_memread, id_memwrite, id_alu_fun,
               hold, flush,
        input  ex_valid, ex_regwrite, ex_memread, ex_memwrite,
               ex_rs1_used, ex_rs2_used, ex_pc, ex_rs1_data, ex_rs2_data,
               ex_imm, ex_rs1, ex_rs2, ex_rd, ex_alu_fun,
               load_stall, bubble_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1, id_rs2, id_rd, id_rs1_used, id_rs2_used,
               id_regwrite, id_memread, id_memwrite, id_alu_fun,
               hold, flush,
        output ex_valid, ex_regwrite, ex_memread, ex_memwrite,
               ex_rs1_used, ex_rs2_used, ex_pc, ex_rs1_data, ex_rs2_data,
               ex_imm, ex_rs1, ex_rs2, ex_rd, ex_alu_fun,
               load_stall, bubble_cnt, flush_cnt
    );
endinterface

// File: rtl/id_ex_reg.sv
// id_ex_reg: ID/EX pipeline register with load-use hazard detection.
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; clears every ex_* output and both
//          counters immediately
//   bus    id_ex_reg_if.slave (decode inputs, hold/flush, ex_* outputs,
//          load_stall and the two saturating event counters)
//
// Each rising edge performs exactly one action, highest priority first:
//   hold   keep everything (load_stall is still reported)
//   flush  insert a bubble, count it in flush_cnt
//   stall  insert a bubble for a load-use hazard, count it in bubble_cnt
//   load   capture the decode slot
// A bubble clears the control flags and register addresses; the data fields
// and ALU opcode keep their previous values.
module id_ex_reg (
    input  logic        clk,
    input  logic        rst_n,
    id_ex_reg_if.slave  bus
);

    typedef enum logic [1:0] {
        ACT_LOAD  = 2'd0,
        ACT_STALL = 2'd1,
        ACT_FLUSH = 2'd2,
        ACT_HOLD  = 2'd3
    } action_t;

    action_t     action;
    logic        hazard;

    logic        ex_valid_q;
    logic        ex_regwrite_q;
    logic        ex_memread_q;
    logic        ex_memwrite_q;
    logic        ex_rs1_used_q;
    logic        ex_rs2_used_q;
    logic [4:0]  ex_rs1_q;
    logic [4:0]  ex_rs2_q;
    logic [4:0]  ex_rd_q;
    logic [31:0] ex_pc_q;
    logic [31:0] ex_rs1_data_q;
    logic [31:0] ex_rs2_data_q;
    logic [31:0] ex_imm_q;
    logic [3:0]  ex_alu_fun_q;
    logic [15:0] bubble_cnt_q;
    logic [15:0] flush_cnt_q;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // A load in EX whose destination is read by the decode instruction.
    // x0 is never a hazard because it is hard-wired to zero.
    always_comb begin
        hazard = ex_valid_q & ex_memread_q & (ex_rd_q != 5'd0) & bus.id_valid &
                 ((bus.id_rs1_used & (bus.id_rs1 == ex_rd_q)) |
                  (bus.id_rs2_used & (bus.id_rs2 == ex_rd_q)));
    end

    // A flush squashes the dependent decode instruction anyway, so there is
    // nothing to stall for.
    assign bus.load_stall = hazard & ~bus.flush;

    always_comb begin
        action = ACT_LOAD;
        if (bus.hold) begin
            action = ACT_HOLD;
        end else if (bus.flush) begin
            action = ACT_FLUSH;
        end else if (bus.load_stall) begin
            action = ACT_STALL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q    <= 1'b0;
            ex_regwrite_q <= 1'b0;
            ex_memread_q  <= 1'b0;
            ex_memwrite_q <= 1'b0;
            ex_rs1_used_q <= 1'b0;
            ex_rs2_used_q <= 1'b0;
            ex_rs1_q      <= 5'd0;
            ex_rs2_q      <= 5'd0;
            ex_rd_q       <= 5'd0;
            ex_pc_q       <= 32'd0;
            ex_rs1_data_q <= 32'd0;
            ex_rs2_data_q <= 32'd0;
            ex_imm_q      <= 32'd0;
            ex_alu_fun_q  <= 4'd0;
            bubble_cnt_q  <= 16'd0;
            flush_cnt_q   <= 16'd0;
        end else begin
            case (action)
                ACT_HOLD: begin
                end
                ACT_FLUSH, ACT_STALL: begin
                    ex_valid_q    <= 1'b0;
                    ex_regwrite_q <= 1'b0;
                    ex_memread_q  <= 1'b0;
                    ex_memwrite_q <= 1'b0;
                    ex_rs1_used_q <= 1'b0;
                    ex_rs2_used_q <= 1'b0;
                    ex_rs1_q      <= 5'd0;
                    ex_rs2_q      <= 5'd0;
                    ex_rd_q       <= 5'd0;
                    if (action == ACT_FLUSH) begin
                        flush_cnt_q <= sat_inc(flush_cnt_q);
                    end else begin
                        bubble_cnt_q <= sat_inc(bubble_cnt_q);
                    end
                end
                ACT_LOAD: begin
                    // An empty decode slot must not carry side effects into EX.
                    ex_valid_q    <= bus.id_valid;
                    ex_regwrite_q <= bus.id_valid & bus.id_regwrite;
                    ex_memread_q  <= bus.id_valid & bus.id_memread;
                    ex_memwrite_q <= bus.id_valid & bus.id_memwrite;
                    ex_rs1_used_q <= bus.id_valid & bus.id_rs1_used;
                    ex_rs2_used_q <= bus.id_valid & bus.id_rs2_used;
                    ex_rs1_q      <= bus.id_rs1;
                    ex_rs2_q      <= bus.id_rs2;
                    ex_rd_q       <= bus.id_rd;
                    ex_pc_q       <= bus.id_pc;
                    ex_rs1_data_q <= bus.id_rs1_data;
                    ex_rs2_data_q <= bus.id_rs2_data;
                    ex_imm_q      <= bus.id_imm;
                    ex_alu_fun_q  <= bus.id_alu_fun;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.ex_valid    = ex_valid_q;
    assign bus.ex_regwrite = ex_regwrite_q;
    assign bus.ex_memread  = ex_memread_q;
    assign bus.ex_memwrite = ex_memwrite_q;
    assign bus.ex_rs1_used = ex_rs1_used_q;
    assign bus.ex_rs2_used = ex_rs2_used_q;
    // Zero-extended so the forwarding unit compares full-width values.
    assign bus.ex_rs1      = {27'd0, ex_rs1_q};
    assign bus.ex_rs2      = {27'd0, ex_rs2_q};
    assign bus.ex_rd       = {27'd0, ex_rd_q};
    assign bus.ex_pc       = ex_pc_q;
    assign bus.ex_rs1_data = ex_rs1_data_q;
    assign bus.ex_rs2_data = ex_rs2_data_q;
    assign bus.ex_imm      = ex_imm_q;
    assign bus.ex_alu_fun  = ex_alu_fun_q;
    assign bus.bubble_cnt  = bubble_cnt_q;
    assign bus.flush_cnt   = flush_cnt_q;

endmodule
